log_mult_dot_accum: RTL and testbench

LOG_MULT_DOT_ACCUM -- requirements
Module: log_mult_dot_accum

---
 rtl/log_mult_dot_accum_pkg.sv | 15 +
 rtl/log_mult_sat32.sv | 29 ++
 rtl/log_mult_dot_accum.sv | 83 ++++++++
 tb/tb_log_mult_dot_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/log_mult_dot_accum_pkg.sv
// Shared log-multiplier definitions: accumulator FSM states, product width and
// the 32-bit saturation limits.
package log_mult_dot_accum_pkg;

  localparam int unsigned PROD_W = 32;

  localparam logic [PROD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [PROD_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic {
    StAccum,
    StHold
  } state_e;

endpackage

// File: rtl/log_mult_sat32.sv
// Combinational clamp of a wide two's-complement accumulator to 32 bits, flagging
// when the value had to be clamped.
module log_mult_sat32
  import log_mult_dot_accum_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [PROD_W-1:0] o_sum,
  output logic              o_ovf
);

  logic [ACC_W-PROD_W:0] upper;
  logic                  fits;

  // The value fits in 32 bits exactly when every bit from 31 upward equals the sign.
  assign upper = i_acc[ACC_W-1:PROD_W-1];
  assign fits  = (&upper) | ~(|upper);

  always_comb begin
    o_sum = i_acc[PROD_W-1:0];
    o_ovf = 1'b0;
    if (!fits) begin
      o_ovf = 1'b1;
      o_sum = i_acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/log_mult_dot_accum.sv
// Accumulates LEN signed products into a wide accumulator, then presents the
// saturated 32-bit dot product until the downstream accepts it.
module log_mult_dot_accum
  import log_mult_dot_accum_pkg::*;
#(
  parameter int unsigned LEN   = 8,
  parameter int unsigned ACC_W = 40
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PROD_W-1:0] i_prod,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PROD_W-1:0] o_sum,
  output logic              o_ovf
);

  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_next;
  logic [PROD_W-1:0]  sat_sum;
  logic               sat_ovf;

  assign acc_next = acc_q + {{(ACC_W-PROD_W){i_prod[PROD_W-1]}}, i_prod};
  assign o_ready  = (state_q == StAccum);

  log_mult_sat32 #(
    .ACC_W(ACC_W)
  ) u_sat (
    .i_acc(acc_next),
    .o_sum(sat_sum),
    .o_ovf(sat_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_ovf   <= 1'b0;
    end else if (i_clear) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (i_valid) begin
            if (cnt_q == LAST) begin
              o_sum   <= sat_sum;
              o_ovf   <= sat_ovf;
              o_valid <= 1'b1;
              state_q <= StHold;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              acc_q <= acc_next;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StHold: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_log_mult_dot_accum.sv
// Self-checking bench for log_mult_dot_accum with LEN = 4: directed vector table,
// hand-written hold/clear/reset sequences and random vectors against a model.
module tb_log_mult_dot_accum;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_prod = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_sum;
  logic        o_ovf;

  int checks = 0;
  int failures = 0;

  log_mult_dot_accum #(
    .LEN  (4),
    .ACC_W(40)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(i_clear),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_prod (i_prod),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum),
    .o_ovf  (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string            name;
    logic [3:0][31:0] p;
    logic [31:0]      sum;
    logic             ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][31:0] pv(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Reference: exact integer sum, then clamp to the signed 32-bit range.
  task automatic model(input logic [3:0][31:0] p, output logic [31:0] s, output logic o);
    longint t;
    t = 0;
    for (int i = 0; i < 4; i++) t += longint'($signed(p[i]));
    if (t > 64'sd2147483647) begin
      s = 32'h7FFF_FFFF;
      o = 1'b1;
    end else if (t < -64'sd2147483648) begin
      s = 32'h8000_0000;
      o = 1'b1;
    end else begin
      s = 32'(t);
      o = 1'b0;
    end
  endtask

  // Present four products, optionally with idle gaps carrying junk data.
  task automatic drive_vec(input string name, input logic [3:0][31:0] p, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        i_valid = 1'b0;
        i_prod  = $urandom;
        step();
      end
      i_valid = 1'b1;
      i_prod  = p[i];
      chk({name, ".ready"}, 32'(o_ready), 32'd1);
      chk({name, ".pre_valid"}, 32'(o_valid), 32'd0);
      step();
    end
    i_valid = 1'b0;
    i_prod  = 32'hDEAD_BEEF;
  endtask

  // Called right after the last accept edge: result must be visible now, stay
  // stable for hold cycles, then drop one cycle after i_ready.
  task automatic finish_vec(input string name, input logic [31:0] s, input logic o,
                            input int hold);
    chk({name, ".valid"}, 32'(o_valid), 32'd1);
    chk({name, ".sum"}, o_sum, s);
    chk({name, ".ovf"}, 32'(o_ovf), 32'(o));
    for (int k = 0; k < hold; k++) begin
      step();
      chk({name, ".hold_valid"}, 32'(o_valid), 32'd1);
      chk({name, ".hold_sum"}, o_sum, s);
      chk({name, ".hold_ready"}, 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({name, ".done_valid"}, 32'(o_valid), 32'd0);
    chk({name, ".done_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    logic [3:0][31:0] p;
    logic [31:0]      s;
    logic             o;

    vecs[0] = '{"basic", pv(32'd1, 32'd2, 32'd3, 32'd4), 32'd10, 1'b0};
    vecs[1] = '{"mixed", pv(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFE, 32'd1), 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{"satpos", pv(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF),
                32'h7FFF_FFFF, 1'b1};
    vecs[3] = '{"satneg", pv(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
                32'h8000_0000, 1'b1};

    // Reset
    step();
    step();
    i_rst_n = 1'b1;
    step();
    chk("reset.ready", 32'(o_ready), 32'd1);
    chk("reset.valid", 32'(o_valid), 32'd0);
    chk("reset.sum", o_sum, 32'd0);
    chk("reset.ovf", 32'(o_ovf), 32'd0);

    // Directed table, downstream always ready
    for (int v = 0; v < 4; v++) begin
      i_ready = 1'b1;
      drive_vec(vecs[v].name, vecs[v].p, 1'b0);
      finish_vec(vecs[v].name, vecs[v].sum, vecs[v].ovf, 0);
    end

    // Backpressure: junk offered during HOLD must not leak into the next vector
    drive_vec("bp", pv(32'd5, 32'd5, 32'd5, 32'd5), 1'b0);
    chk("bp.valid", 32'(o_valid), 32'd1);
    chk("bp.sum", o_sum, 32'd20);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_prod  = 32'd99;
      step();
      chk("bp.stall_sum", o_sum, 32'd20);
      chk("bp.stall_ready", 32'(o_ready), 32'd0);
      chk("bp.stall_valid", 32'(o_valid), 32'd1);
    end
    i_valid = 1'b0;
    finish_vec("bp", 32'd20, 1'b0, 0);
    drive_vec("bp_next", pv(32'd1, 32'd2, 32'd3, 32'd4), 1'b0);
    finish_vec("bp_next", 32'd10, 1'b0, 0);

    // Clear after two terms; the product offered with clear is dropped
    drive_vec("clr_pre", pv(32'd7, 32'd7, 32'd0, 32'd0), 1'b0);
    finish_vec("clr_pre", 32'd14, 1'b0, 0);
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1;
      i_prod  = 32'd7;
      step();
    end
    i_clear = 1'b1;
    i_prod  = 32'd7;
    step();
    i_clear = 1'b0;
    i_valid = 1'b0;
    chk("clr.ready", 32'(o_ready), 32'd1);
    chk("clr.valid", 32'(o_valid), 32'd0);
    drive_vec("clr", pv(32'd1, 32'd1, 32'd1, 32'd1), 1'b0);
    finish_vec("clr", 32'd4, 1'b0, 0);

    // Reset while holding a result
    drive_vec("rst_hold", pv(32'd3, 32'd3, 32'd3, 32'd3), 1'b0);
    chk("rst_hold.sum", o_sum, 32'd12);
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    chk("rst_hold.valid", 32'(o_valid), 32'd0);
    chk("rst_hold.zero", o_sum, 32'd0);
    chk("rst_hold.ready", 32'(o_ready), 32'd1);
    drive_vec("rst_next", pv(32'd2, 32'd2, 32'd2, 32'd2), 1'b0);
    finish_vec("rst_next", 32'd8, 1'b0, 0);

    // Random vectors biased toward the saturation boundaries
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: p[i] = $urandom;
          1: p[i] = 32'($signed($urandom_range(0, 200)) - 100);
          2: p[i] = 32'h7FFF_FFFF - 32'($urandom_range(0, 1000));
          default: p[i] = 32'h8000_0000 + 32'($urandom_range(0, 1000));
        endcase
      end
      model(p, s, o);
      drive_vec("rand", p, 1'b1);
      finish_vec("rand", s, o, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
